mem_io_port: RTL and testbench

//  MEM-stage memory-mapped I/O unit; sits between the EX/MEM pipe register outputs and the data RAM.

---
 rtl/mem_io_port.sv | 108 ++++++++++
 tb/tb_mem_io_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_port.sv
// MEM-stage memory-mapped I/O unit.
// Steers MEM-stage loads/stores either to the data RAM or to three I/O
// registers (OUT, IN, STATUS), drives the output port and captures changes
// on the asynchronous input port through a two-flop synchroniser.
module mem_io_port #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IN_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] IO_BASE    = 32'h1001_0024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] RAM_ReadData,
    input  logic [IN_WIDTH-1:0]   PortIn,
    output logic                  RAM_MemWrite,
    output logic                  RAM_MemRead,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] PortOut,
    output logic                  PortInNew
);

    // Word addresses of the three registers; byte offset bits never decode.
    localparam logic [DATA_WIDTH-3:0] OUT_WORD  = IO_BASE[DATA_WIDTH-1:2];
    localparam logic [DATA_WIDTH-3:0] IN_WORD   = OUT_WORD + (DATA_WIDTH-2)'(1);
    localparam logic [DATA_WIDTH-3:0] STAT_WORD = OUT_WORD + (DATA_WIDTH-2)'(2);

    logic                hit_out, hit_in, hit_stat, io_hit;
    logic [IN_WIDTH-1:0] sync1, sync2, prev;
    logic [IN_WIDTH-1:0] in_data;
    logic                new_flag, overrun;
    logic                change, in_clear, stat_clear, overrun_set;

    assign hit_out  = (Address[DATA_WIDTH-1:2] == OUT_WORD);
    assign hit_in   = (Address[DATA_WIDTH-1:2] == IN_WORD);
    assign hit_stat = (Address[DATA_WIDTH-1:2] == STAT_WORD);
    assign io_hit   = hit_out | hit_in | hit_stat;

    assign RAM_MemWrite = MemWrite & ~io_hit;
    assign RAM_MemRead  = MemRead & ~io_hit;

    // A load that also carries MemWrite is treated as a store: no read side effect.
    assign in_clear    = MemRead & hit_in & ~MemWrite;
    assign stat_clear  = MemWrite & hit_stat & WriteData[1];
    assign change      = (sync2 != prev);
    // An un-acknowledged value is being overwritten, unless this very cycle reads it.
    assign overrun_set = change & new_flag & ~in_clear;

    assign PortInNew = new_flag;

    // Read mux: I/O registers override RAM data whenever the address hits them.
    always_comb begin
        ReadData = RAM_ReadData;
        if (hit_out)
            ReadData = PortOut;
        else if (hit_in)
            ReadData = DATA_WIDTH'(in_data);
        else if (hit_stat)
            ReadData = DATA_WIDTH'({overrun, new_flag});
    end

    // Output port register, written by stores to OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            PortOut <= '0;
        else if (MemWrite && hit_out)
            PortOut <= WriteData;
    end

    // Input synchroniser plus previous-value register for change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Capture on change; a change takes priority over an IN read clearing new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_data  <= '0;
            new_flag <= 1'b0;
        end else if (change) begin
            in_data  <= sync2;
            new_flag <= 1'b1;
        end else if (in_clear) begin
            new_flag <= 1'b0;
        end
    end

    // Sticky overrun flag; setting beats a simultaneous software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrun <= 1'b0;
        else if (overrun_set)
            overrun <= 1'b1;
        else if (stat_clear)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_mem_io_port.sv
// Directed bench for mem_io_port: inputs driven on the falling edge,
// outputs checked on the falling edge or 1ns after a combinational change.
module tb_mem_io_port;

    localparam logic [31:0] A_OUT  = 32'h1001_0024;
    localparam logic [31:0] A_IN   = 32'h1001_0028;
    localparam logic [31:0] A_STAT = 32'h1001_002C;
    localparam logic [31:0] A_RAM  = 32'h1001_0000;
    localparam logic [31:0] RAMD   = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData, RAM_ReadData;
    logic [7:0]  PortIn;
    logic        RAM_MemWrite, RAM_MemRead;
    logic [31:0] ReadData, PortOut;
    logic        PortInNew;

    int checks   = 0;
    int failures = 0;

    mem_io_port dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Address      (Address),
        .WriteData    (WriteData),
        .RAM_ReadData (RAM_ReadData),
        .PortIn       (PortIn),
        .RAM_MemWrite (RAM_MemWrite),
        .RAM_MemRead  (RAM_MemRead),
        .ReadData     (ReadData),
        .PortOut      (PortOut),
        .PortInNew    (PortInNew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, land on the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        MemWrite  = wr;
        MemRead   = rd;
        Address   = a;
        WriteData = wd;
        #1;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, A_RAM, 32'h0);
    endtask

    task automatic read_stat(input string tag, input logic [31:0] exp);
        bus(1'b0, 1'b1, A_STAT, 32'h0);
        check(tag, ReadData, exp);
        idle();
    endtask

    initial begin
        reset        = 1'b0;
        PortIn       = 8'h00;
        RAM_ReadData = RAMD;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        Address      = A_RAM;
        WriteData    = 32'h0;
        tick(2);
        reset = 1'b1;
        tick(1);

        // Reset state and RAM pass-through
        check("rst_portout", PortOut, 32'h0);
        check("rst_new", {31'b0, PortInNew}, 32'h0);
        read_stat("rst_stat", 32'h0);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("rst_in", ReadData, 32'h0);
        check("in_ram_rd_gated", {31'b0, RAM_MemRead}, 32'h0);
        bus(1'b0, 1'b1, A_RAM, 32'h0);
        check("ram_rd_en", {31'b0, RAM_MemRead}, 32'h1);
        check("ram_rdata", ReadData, RAMD);
        bus(1'b1, 1'b0, A_RAM, 32'h1234);
        check("ram_wr_en", {31'b0, RAM_MemWrite}, 32'h1);
        bus(1'b0, 1'b1, 32'h1001_0030, 32'h0);
        check("above_stat_ram", ReadData, RAMD);
        check("above_stat_rden", {31'b0, RAM_MemRead}, 32'h1);
        idle();

        // Store to OUT
        bus(1'b1, 1'b0, A_OUT, 32'hDEADBEEF);
        check("out_ram_wr_gated", {31'b0, RAM_MemWrite}, 32'h0);
        check("out_before_edge", PortOut, 32'h0);
        tick(1);
        idle();
        check("out_portout", PortOut, 32'hDEADBEEF);
        bus(1'b0, 1'b1, A_OUT, 32'h0);
        check("out_lw", ReadData, 32'hDEADBEEF);
        bus(1'b0, 1'b1, 32'h1001_0027, 32'h0);
        check("out_lw_bytelane", ReadData, 32'hDEADBEEF);
        idle();
        // Writes to IN are ignored and do not touch OUT
        bus(1'b1, 1'b0, A_IN, 32'hFFFF_FFFF);
        tick(1);
        idle();
        check("in_write_ignored", PortOut, 32'hDEADBEEF);
        read_stat("in_write_stat", 32'h0);

        // Input capture latency: 0x00 -> 0x5A
        PortIn = 8'h5A;
        tick(2);
        check("cap_new_early", {31'b0, PortInNew}, 32'h0);
        tick(1);
        check("cap_new", {31'b0, PortInNew}, 32'h1);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("cap_lw_in", ReadData, 32'h5A);
        tick(1);
        idle();
        check("cap_new_cleared", {31'b0, PortInNew}, 32'h0);
        read_stat("cap_stat", 32'h0);

        // Two changes without a read -> overrun
        PortIn = 8'h11;
        tick(4);
        PortIn = 8'h22;
        tick(4);
        read_stat("ovr_stat", 32'h3);
        bus(1'b1, 1'b0, A_STAT, 32'h1);
        tick(1);
        idle();
        read_stat("ovr_bit0_ignored", 32'h3);
        bus(1'b1, 1'b0, A_STAT, 32'h2);
        tick(1);
        idle();
        read_stat("ovr_cleared", 32'h1);

        // IN read coinciding with a change while new=1
        PortIn = 8'h33;
        tick(2);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("race_old_value", ReadData, 32'h22);
        tick(1);
        idle();
        read_stat("race_stat", 32'h1);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("race_in_data", ReadData, 32'h33);
        idle();

        // MemRead & MemWrite on IN: no read side effect
        bus(1'b1, 1'b1, A_IN, 32'h0);
        tick(1);
        idle();
        read_stat("rdwr_no_clear", 32'h1);

        // Overrun set beats simultaneous STATUS clear
        PortIn = 8'h44;
        tick(2);
        bus(1'b1, 1'b0, A_STAT, 32'h2);
        tick(1);
        idle();
        read_stat("set_wins", 32'h3);
        bus(1'b1, 1'b0, A_STAT, 32'h2);
        tick(1);
        idle();
        read_stat("set_wins_clear", 32'h1);

        // Reset mid-capture
        PortIn = 8'h55;
        tick(2);
        reset = 1'b0;
        #1;
        check("mrst_portout", PortOut, 32'h0);
        check("mrst_new", {31'b0, PortInNew}, 32'h0);
        read_stat("mrst_stat", 32'h0);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("mrst_in", ReadData, 32'h0);
        bus(1'b0, 1'b1, A_RAM, 32'h0);
        check("mrst_ram_rd", {31'b0, RAM_MemRead}, 32'h1);
        check("mrst_ram_data", ReadData, RAMD);
        bus(1'b1, 1'b0, A_RAM, 32'h0);
        check("mrst_ram_wr", {31'b0, RAM_MemWrite}, 32'h1);
        idle();
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_rst_new_early", {31'b0, PortInNew}, 32'h0);
        tick(1);
        check("post_rst_new", {31'b0, PortInNew}, 32'h1);
        bus(1'b0, 1'b1, A_IN, 32'h0);
        check("post_rst_in", ReadData, 32'h55);
        idle();
        read_stat("post_rst_stat", 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
